// File: rtl/uart_ctrl_if.sv
// Register bus between a host and the UART controller: read/write strobes,
// byte address, write data, combinational read data and decode hit.
interface uart_ctrl_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (
    output rd, wr, addr, wdata,
    input  rdata, hit
  );

  modport slave (
    input  rd, wr, addr, wdata,
    output rdata, hit
  );
endinterface

// File: rtl/uart_ctrl.sv
// Memory-mapped UART: 8N1 transmitter and receiver with independent FSMs,
// a control/status register, sticky status flags and a registered IRQ.
module uart_ctrl #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic       sysclk,
  input  logic       reset,
  uart_ctrl_if.slave bus,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);

  localparam logic [31:0] ADDR_TXD  = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD  = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON  = 32'h4000_0020;
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- bus decode ----------------
  logic w_sel_txd, w_sel_rxd, w_sel_con;
  logic w_wr_txd, w_wr_con, w_rd_rxd, w_rd_con;

  assign w_sel_txd = (bus.addr == ADDR_TXD);
  assign w_sel_rxd = (bus.addr == ADDR_RXD);
  assign w_sel_con = (bus.addr == ADDR_CON);
  assign bus.hit   = w_sel_txd | w_sel_rxd | w_sel_con;

  assign w_wr_txd = bus.wr & w_sel_txd;
  assign w_wr_con = bus.wr & w_sel_con;
  assign w_rd_rxd = bus.rd & w_sel_rxd;
  assign w_rd_con = bus.rd & w_sel_con;

  // ---------------- state declarations ----------------
  logic       r_tx_ie, r_rx_ie;
  logic       r_tx_done, r_rx_valid, r_ovr, r_frm_err;
  logic [7:0] r_rx_byte;
  logic       r_irq;
  logic       w_tx_busy;

  tx_state_t   r_tx_state, w_tx_state_nx;
  logic [15:0] r_tx_cnt, w_tx_cnt_nx;
  logic [2:0]  r_tx_idx, w_tx_idx_nx;
  logic [7:0]  r_tx_data, w_tx_data_nx;
  logic        r_txd, w_txd_nx;
  logic        w_tx_done_set;

  logic        r_rxd_s1, r_rxd_s2, r_rxd_s3;
  rx_state_t   r_rx_state, w_rx_state_nx;
  logic [15:0] r_rx_cnt, w_rx_cnt_nx;
  logic [2:0]  r_rx_idx, w_rx_idx_nx;
  logic [7:0]  r_rx_shift, w_rx_shift_nx;
  logic        w_rx_ok, w_frm_set;

  assign w_tx_busy = (r_tx_state != TX_IDLE);

  // Read mux; returns zero unless a read strobe targets a readable register.
  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (w_sel_rxd)
        bus.rdata = {24'b0, r_rx_byte};
      else if (w_sel_con)
        bus.rdata = {25'b0, r_frm_err, r_ovr, w_tx_busy, r_rx_valid,
                     r_tx_done, r_rx_ie, r_tx_ie};
    end
  end

  // Interrupt enables, the only writable bits of the control register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_tx_ie <= 1'b0;
      r_rx_ie <= 1'b0;
    end else if (w_wr_con) begin
      r_tx_ie <= bus.wdata[0];
      r_rx_ie <= bus.wdata[1];
    end
  end

  // ---------------- transmitter ----------------
  // TX next-state: frame sequencing, bit timing and the next serial level.
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt;
    w_tx_idx_nx   = r_tx_idx;
    w_tx_data_nx  = r_tx_data;
    w_tx_done_set = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_wr_txd) begin
          w_tx_data_nx  = bus.wdata[7:0];
          w_tx_state_nx = TX_START;
          w_tx_cnt_nx   = '0;
          w_tx_idx_nx   = '0;
        end
      end
      TX_START: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nx   = '0;
          w_tx_state_nx = TX_DATA;
        end else begin
          w_tx_cnt_nx = r_tx_cnt + 16'd1;
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nx = '0;
          if (r_tx_idx == 3'd7)
            w_tx_state_nx = TX_STOP;
          else
            w_tx_idx_nx = r_tx_idx + 3'd1;
        end else begin
          w_tx_cnt_nx = r_tx_cnt + 16'd1;
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nx   = '0;
          w_tx_state_nx = TX_IDLE;
          w_tx_done_set = 1'b1;
        end else begin
          w_tx_cnt_nx = r_tx_cnt + 16'd1;
        end
      end
      default: w_tx_state_nx = TX_IDLE;
    endcase

    // Line level is registered from the next state so txd changes in the
    // same cycle as the state and never glitches on state decode.
    case (w_tx_state_nx)
      TX_START: w_txd_nx = 1'b0;
      TX_DATA:  w_txd_nx = w_tx_data_nx[w_tx_idx_nx];
      default:  w_txd_nx = 1'b1;
    endcase
  end

  // TX state register; reset forces the line idle-high immediately.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_data  <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_idx   <= w_tx_idx_nx;
      r_tx_data  <= w_tx_data_nx;
      r_txd      <= w_txd_nx;
    end
  end

  assign txd = r_txd;

  // ---------------- receiver ----------------
  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_rxd_s3 <= 1'b1;
    end else begin
      r_rxd_s1 <= rxd;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_s3 <= r_rxd_s2;
    end
  end

  // RX next-state: start validation at mid-bit, data sampling, stop check.
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt;
    w_rx_idx_nx   = r_rx_idx;
    w_rx_shift_nx = r_rx_shift;
    w_rx_ok       = 1'b0;
    w_frm_set     = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rxd_s3 & ~r_rxd_s2) begin
          w_rx_state_nx = RX_START;
          w_rx_cnt_nx   = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nx = '0;
          w_rx_idx_nx = '0;
          if (r_rxd_s2)
            w_rx_state_nx = RX_IDLE;
          else
            w_rx_state_nx = RX_DATA;
        end else begin
          w_rx_cnt_nx = r_rx_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nx   = '0;
          w_rx_shift_nx = {r_rxd_s2, r_rx_shift[7:1]};
          if (r_rx_idx == 3'd7)
            w_rx_state_nx = RX_STOP;
          else
            w_rx_idx_nx = r_rx_idx + 3'd1;
        end else begin
          w_rx_cnt_nx = r_rx_cnt + 16'd1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nx   = '0;
          w_rx_state_nx = RX_IDLE;
          if (r_rxd_s2)
            w_rx_ok = 1'b1;
          else
            w_frm_set = 1'b1;
        end else begin
          w_rx_cnt_nx = r_rx_cnt + 16'd1;
        end
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_idx   <= w_rx_idx_nx;
      r_rx_shift <= w_rx_shift_nx;
    end
  end

  // ---------------- status flags and interrupt ----------------
  // Sticky flags: the set condition is tested first so it beats a clear.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_ovr      <= 1'b0;
      r_frm_err  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      if (w_rx_ok)
        r_rx_byte <= r_rx_shift;

      if (w_rx_ok)
        r_rx_valid <= 1'b1;
      else if (w_rd_rxd)
        r_rx_valid <= 1'b0;

      if (w_rx_ok & r_rx_valid)
        r_ovr <= 1'b1;
      else if (w_rd_con)
        r_ovr <= 1'b0;

      if (w_frm_set)
        r_frm_err <= 1'b1;
      else if (w_rd_con)
        r_frm_err <= 1'b0;

      if (w_tx_done_set)
        r_tx_done <= 1'b1;
      else if (w_rd_con)
        r_tx_done <= 1'b0;
    end
  end

  // Level interrupt, registered from the already-registered flags.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)
      r_irq <= 1'b0;
    else
      r_irq <= (r_tx_done & r_tx_ie) | (r_rx_valid & r_rx_ie);
  end

  assign irq = r_irq;

endmodule
